fc_stream_neuron: RTL and testbench
===================================

# fc_stream_neuron

Time-multiplexed, parametrised successor to the fully-combinational fully-connected layer neuron. It computes OUT parallel output channels over a streamed input vector of IN signed samples. Each accepted beat performs one multiply-accumulate per channel using runtime weights. After the last beat it adds a per-channel bias, applies an optional ReLU, and holds the result behind a valid/ready output. It sits between a feature-map streamer (or previous layer) and the next layer, and trades the constant-coefficient multiplier tree for IN cycles of latency and runtime-loadable weights.

## Interface
- WIDTH, 8: signed input sample and weight width.
- IN, 128: input vector length per frame; must be ≥ 2.
- OUT, 4: number of output channels (neurons) computed in parallel.
- ACC_W, derived = 2*WIDTH + $clog2(IN): accumulator width per channel.
- Z_W, derived = ACC_W + 1: output width; bias add cannot overflow.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- x_valid  in  1  input beat valid.
- x_ready  out  1  block can accept a beat.
- x  in  WIDTH  signed input sample.
- w  in  [0:OUT-1][WIDTH]  signed weights for the current beat, one per channel; qualified with x_valid.
- bias  in  [0:OUT-1][2*WIDTH]  signed per-channel bias; sampled at output load.
- relu_en  in  1  ReLU mode; sampled on the first beat of each frame.
- z_valid  out  1  results valid.
- z_ready  in  1  downstream accepts results.
- z  out  [0:OUT-1][Z_W]  signed channel results, registered.
- beat_idx  out  $clog2(IN)  index of the next beat to be accepted (0..IN-1).

## Operation
- States: ACCUM, DRAIN, OUTPUT.
- ACCUM: x_ready=1. A beat is accepted when x_valid && x_ready.
  - Pipeline stage 1 registers prod[c] = x*w[c] as a signed 2*WIDTH value, plus a prod_valid flag.
  - Stage 2 adds the sign-extended prod[c] into acc[c] when prod_valid.
  - beat_idx increments per accepted beat.
  - On accepting beat IN-1: beat_idx wraps to 0 and the state goes to DRAIN.
- DRAIN: x_ready=0; lasts 2 cycles (cnt), letting stage 1 and stage 2 retire.
  - At the end of the second DRAIN cycle: z[c] = f(sext(acc[c]) + sext(bias[c])), acc cleared to 0, state goes to OUTPUT.
  - f = max(0, ·) if the sampled relu_en=1, otherwise the identity.
- OUTPUT: z_valid=1, x_ready=0, z held stable. On z_valid && z_ready, go to ACCUM; z keeps its value until the next load.
- relu_en is latched on beat 0 only; changes mid-frame have no effect.
- Beats offered while x_ready=0 are ignored.
- Bubbles (x_valid=0) in ACCUM do not alter state.
- All arithmetic is two's-complement signed; sign-extend before every add. The accumulator cannot overflow by construction (ACC_W), so there is no saturation.

## Timing
- Reset values (async assert, sync release):
  - state=ACCUM, beat_idx=0, acc=0, prod=0, prod_valid=0, relu latch=0, DRAIN counter=0.
  - z_valid=0, z=0. x_ready=1 from the first cycle after reset deassertion.
- Latency: last beat accepted in cycle t gives z_valid=1 in cycle t+3, with x_ready=0 in cycles t+1 through the handshake cycle.
- x_ready returns to 1 in the cycle after the z handshake. Minimum frame period is IN+3 cycles with z_ready held high.
- Reset mid-frame discards all partial sums and any pending output. The next frame starts at beat 0.
- No combinational path exists from x_valid/z_ready to x_ready/z_valid; both outputs are decoded from registered state only.

## Test plan
- WIDTH=8, IN=4, OUT=2, x=[1,2,3,4], w0=1 for all beats, w1=-1 for all beats, bias=0, relu_en=1 -> z0=10, z1=0. Repeat with relu_en=0 -> z1=-10.
- Extremes: x=-128 and w0=-128 on all 4 beats, w1=127, relu_en=0, bias0=5, bias1=-32768 -> z0=65541, z1=-97792. No wrap at Z_W=19.
- Back-pressure: hold z_ready=0 for 5 cycles after z_valid -> z and z_valid stable. x_ready=0 throughout; x_valid=1 beats during the stall are ignored. Release gives x_ready=1 next cycle.
- Bubbles: insert x_valid=0 gaps between beats of scenario 1 -> identical results. z_valid exactly 3 cycles after the last beat; beat_idx reads 0,1,2,3 then 0.
- Reset asserted asynchronously after 2 beats -> z_valid=0, z=0, beat_idx=0 immediately. A fresh 4-beat frame then gives the scenario 1 values.
- Back-to-back frames with z_ready=1: second frame relu_en differs and relu_en toggles mid-frame -> each frame uses its beat-0 mode. Frame period is 7 cycles.

Source files
------------

// File: rtl/fc_stream_neuron_if.sv
// Streaming interface for fc_stream_neuron: input beat handshake with
// per-channel weights, per-channel bias and ReLU mode, and the registered
// result handshake.
interface fc_stream_neuron_if #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int OUT   = 4
);
    localparam int ACC_W = 2 * WIDTH + $clog2(IN);
    localparam int Z_W   = ACC_W + 1;
    localparam int IDX_W = $clog2(IN);

    logic                      x_valid;
    logic                      x_ready;
    logic signed [WIDTH-1:0]   x;
    logic signed [WIDTH-1:0]   w [OUT];
    logic signed [2*WIDTH-1:0] bias [OUT];
    logic                      relu_en;
    logic                      z_valid;
    logic                      z_ready;
    logic signed [Z_W-1:0]     z [OUT];
    logic [IDX_W-1:0]          beat_idx;

    // Producer side: feeds beats and consumes results.
    modport master (
        output x_valid, x, w, bias, relu_en, z_ready,
        input  x_ready, z_valid, z, beat_idx
    );

    // Neuron side.
    modport slave (
        input  x_valid, x, w, bias, relu_en, z_ready,
        output x_ready, z_valid, z, beat_idx
    );
endinterface

// File: rtl/fc_stream_neuron.sv
// Time-multiplexed fully-connected neuron block: OUT channels accumulate
// x*w over IN streamed beats through a two-stage MAC pipeline, then add a
// per-channel bias, apply optional ReLU and present the result behind a
// valid/ready handshake.
module fc_stream_neuron #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int OUT   = 4
) (
    input logic               clk,
    input logic               rst,
    fc_stream_neuron_if.slave s
);
    localparam int P_W   = 2 * WIDTH;
    localparam int ACC_W = P_W + $clog2(IN);
    localparam int Z_W   = ACC_W + 1;
    localparam int IDX_W = $clog2(IN);

    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

    state_t                  state_q, state_d;
    logic                    cnt_q, cnt_d;
    logic                    accept;
    logic                    last_beat;
    logic                    load;
    logic [IDX_W-1:0]        beat_idx_q;
    logic                    relu_q;
    logic signed [P_W-1:0]   prod_p1 [OUT];
    logic                    vld_p1;
    logic signed [ACC_W-1:0] acc_p2 [OUT];
    logic signed [Z_W-1:0]   z_q [OUT];

    function automatic logic signed [P_W-1:0] sext_in(input logic signed [WIDTH-1:0] v);
        return {{(P_W - WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [P_W-1:0] v);
        return {{(ACC_W - P_W){v[P_W-1]}}, v};
    endfunction

    function automatic logic signed [Z_W-1:0] sext_acc(input logic signed [ACC_W-1:0] v);
        return {v[ACC_W-1], v};
    endfunction

    function automatic logic signed [Z_W-1:0] sext_bias(input logic signed [P_W-1:0] v);
        return {{(Z_W - P_W){v[P_W-1]}}, v};
    endfunction

    function automatic logic signed [Z_W-1:0] relu(input logic signed [Z_W-1:0] v,
                                                   input logic              en);
        return (en && v[Z_W-1]) ? '0 : v;
    endfunction

    // Handshake and load strobes decode from registered state only, so no
    // combinational path runs from x_valid/z_ready to x_ready/z_valid.
    assign accept     = s.x_valid && (state_q == ACCUM);
    assign last_beat  = (beat_idx_q == IDX_W'(IN - 1));
    assign load       = (state_q == DRAIN) && cnt_q;
    assign s.x_ready  = (state_q == ACCUM);
    assign s.z_valid  = (state_q == OUTPUT);
    assign s.beat_idx = beat_idx_q;
    assign s.z        = z_q;

    // State and drain-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; DRAIN holds two cycles so both MAC stages retire.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACCUM: begin
                if (accept && last_beat) begin
                    state_d = DRAIN;
                    cnt_d   = 1'b0;
                end
            end
            DRAIN: begin
                if (cnt_q) begin
                    state_d = OUTPUT;
                    cnt_d   = 1'b0;
                end else begin
                    cnt_d = 1'b1;
                end
            end
            OUTPUT: begin
                if (s.z_ready) state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
                cnt_d   = 1'b0;
            end
        endcase
    end

    // Beat index and frame ReLU mode, captured on beat 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx_q <= '0;
            relu_q     <= 1'b0;
        end else if (accept) begin
            beat_idx_q <= last_beat ? '0 : beat_idx_q + 1'b1;
            if (beat_idx_q == '0) relu_q <= s.relu_en;
        end
    end

    // Stage 1: per-channel product of the accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            for (int c = 0; c < OUT; c++) prod_p1[c] <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                for (int c = 0; c < OUT; c++) prod_p1[c] <= sext_in(s.x) * sext_in(s.w[c]);
            end
        end
    end

    // Stage 2: accumulate, then bias/ReLU into the output register at load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < OUT; c++) begin
                acc_p2[c] <= '0;
                z_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < OUT; c++) begin
                if (load) begin
                    z_q[c]    <= relu(sext_acc(acc_p2[c]) + sext_bias(s.bias[c]), relu_q);
                    acc_p2[c] <= '0;
                end else if (vld_p1) begin
                    acc_p2[c] <= acc_p2[c] + sext_prod(prod_p1[c]);
                end
            end
        end
    end
endmodule

// File: tb/tb_fc_stream_neuron.sv
// Directed bench for fc_stream_neuron (WIDTH=8, IN=4, OUT=2): table of
// frames with hand-computed results, plus back-pressure, bubble and
// mid-frame reset sequences.
module tb_fc_stream_neuron;
    localparam int WIDTH = 8;
    localparam int IN    = 4;
    localparam int OUT   = 2;
    localparam int NV    = 5;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Free-running edge counter used to measure frame period.
    always @(posedge clk) cyc <= cyc + 1;

    fc_stream_neuron_if #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT)) bus ();

    fc_stream_neuron #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    typedef struct {
        int     x  [IN];
        int     w0 [IN];
        int     w1 [IN];
        int     b0;
        int     b1;
        bit     relu;
        longint z0;
        longint z1;
    } vec_t;

    vec_t tv [NV];

    task automatic chk(input string name, input longint act, input longint exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams one frame (beat 0 carries the frame's relu mode, later beats
    // carry the opposite) and checks the output timing and values. Returns
    // in the first OUTPUT cycle; the handshake depends on z_ready.
    task automatic send_frame(input vec_t v, input bit gaps, input string tag,
                              output int t_start);
        t_start = 0;
        bus.bias[0] = 16'(v.b0);
        bus.bias[1] = 16'(v.b1);
        for (int i = 0; i < IN; i++) begin
            if (gaps) begin
                bus.x_valid = 1'b0;
                step();
                step();
            end
            chk($sformatf("%s beat_idx%0d", tag, i), longint'(bus.beat_idx), longint'(i));
            chk($sformatf("%s x_ready%0d", tag, i), longint'(bus.x_ready), 1);
            bus.x       = WIDTH'(v.x[i]);
            bus.w[0]    = WIDTH'(v.w0[i]);
            bus.w[1]    = WIDTH'(v.w1[i]);
            bus.relu_en = (i == 0) ? v.relu : !v.relu;
            bus.x_valid = 1'b1;
            if (i == 0) t_start = cyc;
            step();
        end
        bus.x_valid = 1'b0;
        chk({tag, " beat_idx wrap"}, longint'(bus.beat_idx), 0);
        chk({tag, " x_ready t+1"}, longint'(bus.x_ready), 0);
        chk({tag, " z_valid t+1"}, longint'(bus.z_valid), 0);
        step();
        chk({tag, " z_valid t+2"}, longint'(bus.z_valid), 0);
        step();
        chk({tag, " z_valid t+3"}, longint'(bus.z_valid), 1);
        chk({tag, " x_ready t+3"}, longint'(bus.x_ready), 0);
        chk({tag, " z0"}, longint'(bus.z[0]), v.z0);
        chk({tag, " z1"}, longint'(bus.z[1]), v.z1);
    endtask

    initial begin
        int t_prev;
        int t_now;
        vec_t hold;

        tv[0] = '{'{1, 2, 3, 4}, '{1, 1, 1, 1}, '{-1, -1, -1, -1}, 0, 0, 1'b1, 10, 0};
        tv[1] = '{'{1, 2, 3, 4}, '{1, 1, 1, 1}, '{-1, -1, -1, -1}, 0, 0, 1'b0, 10, -10};
        tv[2] = '{'{-128, -128, -128, -128}, '{-128, -128, -128, -128},
                  '{127, 127, 127, 127}, 5, -32768, 1'b0, 65541, -97792};
        tv[3] = '{'{-1, -2, -3, -4}, '{2, 2, 2, 2}, '{-3, -3, -3, -3}, 3, 50, 1'b1, 0, 80};
        tv[4] = '{'{-1, -2, -3, -4}, '{2, 2, 2, 2}, '{-3, -3, -3, -3}, 3, 50, 1'b0, -17, 80};

        rst         = 1'b1;
        bus.x_valid = 1'b0;
        bus.x       = '0;
        bus.w[0]    = '0;
        bus.w[1]    = '0;
        bus.bias[0] = '0;
        bus.bias[1] = '0;
        bus.relu_en = 1'b0;
        bus.z_ready = 1'b1;

        step();
        step();
        chk("reset z_valid", longint'(bus.z_valid), 0);
        chk("reset beat_idx", longint'(bus.beat_idx), 0);
        chk("reset z0", longint'(bus.z[0]), 0);
        chk("reset z1", longint'(bus.z[1]), 0);
        rst = 1'b0;
        step();
        chk("post-reset x_ready", longint'(bus.x_ready), 1);

        // Table frames, back to back with z_ready held high.
        t_prev = -1;
        for (int i = 0; i < NV; i++) begin
            send_frame(tv[i], 1'b0, $sformatf("v%0d", i), t_now);
            if (t_prev >= 0) chk($sformatf("v%0d period", i), longint'(t_now - t_prev), 7);
            t_prev = t_now;
            step();
            chk($sformatf("v%0d x_ready after hs", i), longint'(bus.x_ready), 1);
            chk($sformatf("v%0d z_valid after hs", i), longint'(bus.z_valid), 0);
            chk($sformatf("v%0d z0 held", i), longint'(bus.z[0]), tv[i].z0);
        end

        // Back-pressure: results hold while stalled, stray beats ignored.
        bus.z_ready = 1'b0;
        send_frame(tv[0], 1'b0, "bp", t_now);
        for (int k = 0; k < 5; k++) begin
            bus.x       = 8'sd7;
            bus.w[0]    = 8'sd9;
            bus.w[1]    = 8'sd9;
            bus.x_valid = 1'b1;
            step();
            chk($sformatf("bp z_valid%0d", k), longint'(bus.z_valid), 1);
            chk($sformatf("bp x_ready%0d", k), longint'(bus.x_ready), 0);
            chk($sformatf("bp z0 stable%0d", k), longint'(bus.z[0]), 10);
            chk($sformatf("bp z1 stable%0d", k), longint'(bus.z[1]), 0);
        end
        bus.x_valid = 1'b0;
        bus.z_ready = 1'b1;
        step();
        chk("bp x_ready release", longint'(bus.x_ready), 1);
        chk("bp beat_idx release", longint'(bus.beat_idx), 0);
        send_frame(tv[1], 1'b0, "bp next", t_now);
        step();

        // Bubbles between beats give identical results.
        send_frame(tv[0], 1'b1, "bubble", t_now);
        step();

        // Asynchronous reset after two beats discards the partial frame.
        hold = tv[2];
        bus.bias[0] = 16'(hold.b0);
        bus.bias[1] = 16'(hold.b1);
        for (int i = 0; i < 2; i++) begin
            bus.x       = WIDTH'(hold.x[i]);
            bus.w[0]    = WIDTH'(hold.w0[i]);
            bus.w[1]    = WIDTH'(hold.w1[i]);
            bus.relu_en = 1'b0;
            bus.x_valid = 1'b1;
            step();
        end
        bus.x_valid = 1'b0;
        chk("pre-rst beat_idx", longint'(bus.beat_idx), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst z_valid", longint'(bus.z_valid), 0);
        chk("async rst z0", longint'(bus.z[0]), 0);
        chk("async rst beat_idx", longint'(bus.beat_idx), 0);
        step();
        rst = 1'b0;
        step();
        send_frame(tv[0], 1'b0, "after rst", t_now);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d tests run", n_run);
        $fatal(1, "timeout");
    end
endmodule
